// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Owner tags say which pipeline port a read response belongs to.
package mem_arb_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int MAX_OUT_DEF    = 2;
   localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/tag_fifo.sv
// In-order owner-tag FIFO: one entry per outstanding memory read.
// Pushes while full and pops while empty are ignored.
module tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = MAX_OUT_DEF
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   i_push,
   input  owner_t i_tag,
   input  logic   i_pop,
   output owner_t o_tag,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   owner_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_tag     = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop)
            r_count <= r_count - 1'b1;
      end
   end

   // Tag storage carries no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_tag;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the IF fetch port and the MEM load/store port.
// Data has priority; a waiting fetch wins once STARVE_MAX data grants have gone by.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MAX_OUT    = MAX_OUT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic          m_rvalid,
   input  logic [DW-1:0] m_rdata,
   output logic          err
);

   logic          w_sel_if;
   logic          w_sel_d;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_push;
   logic          w_pop;
   owner_t        w_push_tag;
   owner_t        w_pop_tag;
   logic [3:0]    r_starve_cnt;
   logic          r_if_rvalid;
   logic          r_d_rvalid;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_err;

   always_comb begin
      w_sel_if = 1'b0;
      w_sel_d  = 1'b0;
      if (if_req && (r_starve_cnt == 4'(STARVE_MAX)))
         w_sel_if = 1'b1;
      else if (d_req)
         w_sel_d = 1'b1;
      else if (if_req)
         w_sel_if = 1'b1;
   end

   // A full tag FIFO stalls every issue, stores included, so ordering stays simple.
   assign m_req   = reset & (w_sel_if | w_sel_d) & ~w_fifo_full;
   assign if_gnt  = w_sel_if & m_req & m_ready;
   assign d_gnt   = w_sel_d & m_req & m_ready;
   assign m_we    = w_sel_d & d_we;
   assign m_addr  = w_sel_d ? d_addr : if_addr;
   assign m_wdata = w_sel_d ? d_wdata : '0;

   assign w_push     = if_gnt | (d_gnt & ~d_we);
   assign w_push_tag = if_gnt ? OWN_IF : OWN_D;
   assign w_pop      = m_rvalid & ~w_fifo_empty;

   tag_fifo #(
      .DEPTH (MAX_OUT)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_tag   (w_push_tag),
      .i_pop   (w_pop),
      .o_tag   (w_pop_tag),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         r_starve_cnt <= '0;
      end else if (d_gnt && (r_starve_cnt != 4'(STARVE_MAX))) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_if_rvalid <= w_pop && (w_pop_tag == OWN_IF);
         r_d_rvalid  <= w_pop && (w_pop_tag == OWN_D);
         if (w_pop && (w_pop_tag == OWN_IF)) r_if_rdata <= m_rdata;
         if (w_pop && (w_pop_tag == OWN_D))  r_d_rdata  <= m_rdata;
         // A response nobody asked for is a protocol violation; latch it.
         if (m_rvalid && w_fifo_empty) r_err <= 1'b1;
      end
   end

   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rvalid  = r_d_rvalid;
   assign d_rdata   = r_d_rdata;
   assign err       = r_err;

endmodule
